// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Streaming encoder that turns decoded micro-op fields back into the 32-bit
// Kiana SIMT instruction word accepted by the front-end decoder. Beats enter
// through a valid/ready slave port, are encoded combinationally, and are
// written into a 2-entry FIFO that drives the valid/ready master port.
// Opcodes above 42 are dropped and reported. If such a beat closes a packet,
// a NOP carrying tlast is emitted instead, so packet framing survives.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   s_tvalid/tready  input handshake (tready = FIFO not full)
//   s_tlast          last beat of a kernel packet
//   opcode           internal opcode number (0..42 valid)
//   rd, rs1, rs2     register fields
//   imm              packed immediate in the decoder's layout
//   warp_id_in       warp id, carried alongside the word
//   m_tvalid/tready  output handshake (tvalid = FIFO not empty)
//   instruction      encoded word at the FIFO head
//   warp_id_out      warp id at the FIFO head
//   m_tlast          tlast at the FIFO head
//   err              one-cycle error code, 0 when idle
//   drop_count       saturating count of dropped invalid beats
// -----------------------------------------------------------------------------
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    input  logic [7:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic [4:0]  warp_id_in,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] instruction,
    output logic [4:0]  warp_id_out,
    output logic        m_tlast,
    output logic [31:0] err,
    output logic [15:0] drop_count
);

    // Error code reported for an unknown opcode.
    localparam logic [31:0] ERR_UNKNOWN_OPCODE = 32'h0000_0101;

    // Base opcodes (bits [6:0]) of each format group.
    localparam logic [6:0] BASE_BRANCH = 7'b1100011;
    localparam logic [6:0] BASE_LOAD   = 7'b0000011;
    localparam logic [6:0] BASE_STORE  = 7'b0100011;
    localparam logic [6:0] BASE_ALU_I  = 7'b0010011;
    localparam logic [6:0] BASE_ALU_R  = 7'b0110011;
    localparam logic [6:0] BASE_SYNC   = 7'b0001111;
    localparam logic [6:0] BASE_JAL    = 7'b1101111;
    localparam logic [6:0] BASE_JALR   = 7'b1100111;
    localparam logic [6:0] BASE_LUI    = 7'b0110111;
    localparam logic [6:0] BASE_AUIPC  = 7'b0010111;
    localparam logic [6:0] BASE_PTYPE  = 7'b1110011;

    localparam logic [6:0]  F7_ALT    = 7'b0100000;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [7:0]  MAX_OP    = 8'd42;
    localparam logic [1:0]  FIFO_FULL = 2'd2;

    // -------------------------------------------------------------------------
    // Combinational encoder
    // -------------------------------------------------------------------------
    logic [6:0]  base;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic [31:0] imm_bits;   // immediate already placed at its word position
    logic        op_valid;
    logic [31:0] enc_word;
    logic [31:0] push_word;

    // Format group: base opcode, which register fields are live, and where
    // the immediate lands. Fields a format does not use stay 0, so the
    // final word is an OR of the pieces.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the case, so no path through it can infer a latch.
        base     = '0;
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        imm_bits = '0;
        op_valid = 1'b1;
        case (opcode) inside
            [8'd0:8'd5]: begin
                base     = BASE_BRANCH;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                // Branch offset scattered over [31:26], [25] and [11:7].
                imm_bits = {imm[23:18], imm[7], 13'd0, imm[6:2], 7'd0};
            end
            [8'd6:8'd10]: begin
                base    = BASE_LOAD;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            [8'd11:8'd13]: begin
                base    = BASE_STORE;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            [8'd14:8'd19]: begin
                base     = BASE_ALU_I;
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
                imm_bits = {imm[11:0], 20'd0};
            end
            [8'd20:8'd22]: begin
                // Shift-immediate: shamt sits in the rs2 slot, f7 above it.
                base     = BASE_ALU_I;
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
                imm_bits = {7'd0, imm[4:0], 20'd0};
            end
            [8'd23:8'd32]: begin
                base    = BASE_ALU_R;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            [8'd33:8'd35]: begin
                base = BASE_SYNC;
            end
            8'd36: begin
                base     = BASE_JAL;
                use_rd   = 1'b1;
                imm_bits = {imm[21:2], 12'd0};
            end
            8'd37: begin
                base     = BASE_JALR;
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
                imm_bits = {imm[13:2], 20'd0};
            end
            8'd38: begin
                base     = BASE_LUI;
                use_rd   = 1'b1;
                imm_bits = {imm[31:12], 12'd0};
            end
            8'd39: begin
                base     = BASE_AUIPC;
                use_rd   = 1'b1;
                imm_bits = {imm[31:12], 12'd0};
            end
            [8'd40:8'd42]: begin
                base = BASE_PTYPE;
                // Only the first P-type op carries an immediate; it overlays
                // the f7/rs2/rs1 and rd slots.
                if (opcode == 8'd40) begin
                    imm_bits = {imm[28:18], imm[12:7], 3'd0, imm[6:2], 7'd0};
                end
            end
            default: begin
                op_valid = 1'b0;
            end
        endcase
    end

    // funct3 / funct7 per opcode.
    always_comb begin
        f3 = '0;
        f7 = '0;
        case (opcode)
            // Branches
            8'd0:  f3 = 3'b000;
            8'd1:  f3 = 3'b001;
            8'd2:  f3 = 3'b100;
            8'd3:  f3 = 3'b101;
            8'd4:  f3 = 3'b110;
            8'd5:  f3 = 3'b111;
            // Loads
            8'd6:  f3 = 3'b000;
            8'd7:  f3 = 3'b001;
            8'd8:  f3 = 3'b010;
            8'd9:  f3 = 3'b100;
            8'd10: f3 = 3'b101;
            // Stores
            8'd11: f3 = 3'b000;
            8'd12: f3 = 3'b001;
            8'd13: f3 = 3'b010;
            // I-type ALU
            8'd14: f3 = 3'b000;
            8'd15: f3 = 3'b010;
            8'd16: f3 = 3'b011;
            8'd17: f3 = 3'b100;
            8'd18: f3 = 3'b110;
            8'd19: f3 = 3'b111;
            8'd20: f3 = 3'b001;
            8'd21: f3 = 3'b101;
            8'd22: begin f3 = 3'b101; f7 = F7_ALT; end
            // R-type ALU
            8'd23: f3 = 3'b000;
            8'd24: begin f3 = 3'b000; f7 = F7_ALT; end
            8'd25: f3 = 3'b001;
            8'd26: f3 = 3'b010;
            8'd27: f3 = 3'b011;
            8'd28: f3 = 3'b100;
            8'd29: f3 = 3'b101;
            8'd30: begin f3 = 3'b101; f7 = F7_ALT; end
            8'd31: f3 = 3'b110;
            8'd32: f3 = 3'b111;
            // Sync
            8'd33: f3 = 3'b000;
            8'd34: f3 = 3'b001;
            8'd35: f3 = 3'b010;
            // P-type
            8'd40: f3 = 3'b101;
            8'd41: f3 = 3'b110;
            8'd42: f3 = 3'b111;
            default: begin
                f3 = '0;
                f7 = '0;
            end
        endcase
    end

    assign enc_word = {f7,
                       use_rs2 ? rs2 : 5'd0,
                       use_rs1 ? rs1 : 5'd0,
                       f3,
                       use_rd  ? rd  : 5'd0,
                       base} | imm_bits;

    // An invalid beat that closes a packet is replaced by a NOP.
    assign push_word = op_valid ? enc_word : NOP_WORD;

    // -------------------------------------------------------------------------
    // Handshake and 2-entry FIFO
    // -------------------------------------------------------------------------
    logic [31:0] word_q [2];
    logic [4:0]  warp_q [2];
    logic        last_q [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        accept;
    logic        push;
    logic        pop;

    // Ready depends on occupancy only, so a full FIFO refuses input even in
    // a cycle where the head is being drained.
    assign s_tready = (count != FIFO_FULL);
    assign m_tvalid = (count != 2'd0);
    assign accept   = s_tvalid && s_tready;
    assign push     = accept && (op_valid || s_tlast);
    assign pop      = m_tvalid && m_tready;

    assign instruction = word_q[rd_ptr];
    assign warp_id_out = warp_q[rd_ptr];
    assign m_tlast     = last_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two storage entries are reset because the head entry
            // drives the outputs directly and must read 0 out of reset.
            for (int i = 0; i < 2; i++) begin
                word_q[i] <= '0;
                warp_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= '0;
            err        <= '0;
            drop_count <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples its inputs as they were before this edge.
            if (push) begin
                word_q[wr_ptr] <= push_word;
                warp_q[wr_ptr] <= warp_id_in;
                last_q[wr_ptr] <= s_tlast;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};

            // Error code is live only in the cycle after an invalid beat.
            err <= (accept && !op_valid) ? ERR_UNKNOWN_OPCODE : '0;

            if (accept && !op_valid && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. Every beat the bench drives pushes an
// expectation onto a scoreboard queue; a monitor pops and compares on each
// output handshake. Output words are checked against fixed values where a
// known encoding exists, and otherwise by decoding them with a small model of
// the front-end decoder and comparing the fields each format uses.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [7:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [4:0]  warp_id_in;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] instruction;
    logic [4:0]  warp_id_out;
    logic        m_tlast;
    logic [31:0] err;
    logic [15:0] drop_count;

    instr_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tlast     (s_tlast),
        .opcode      (opcode),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .warp_id_in  (warp_id_in),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .instruction (instruction),
        .warp_id_out (warp_id_out),
        .m_tlast     (m_tlast),
        .err         (err),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [4:0]  warp;
        logic        last;
        logic        has_word;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- decoder model ----------------
    function automatic int dec_op(input logic [31:0] w);
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        case (w[6:0])
            7'b1100011: case (f3)
                3'b000: return 0;  3'b001: return 1;  3'b100: return 2;
                3'b101: return 3;  3'b110: return 4;  3'b111: return 5;
                default: return -1;
            endcase
            7'b0000011: case (f3)
                3'b000: return 6;  3'b001: return 7;  3'b010: return 8;
                3'b100: return 9;  3'b101: return 10;
                default: return -1;
            endcase
            7'b0100011: case (f3)
                3'b000: return 11; 3'b001: return 12; 3'b010: return 13;
                default: return -1;
            endcase
            7'b0010011: case (f3)
                3'b000: return 14; 3'b010: return 15; 3'b011: return 16;
                3'b100: return 17; 3'b110: return 18; 3'b111: return 19;
                3'b001: return 20;
                default: return (f7 == 7'b0100000) ? 22 : 21;
            endcase
            7'b0110011: case ({f7, f3})
                10'b0000000_000: return 23; 10'b0100000_000: return 24;
                10'b0000000_001: return 25; 10'b0000000_010: return 26;
                10'b0000000_011: return 27; 10'b0000000_100: return 28;
                10'b0000000_101: return 29; 10'b0100000_101: return 30;
                10'b0000000_110: return 31; 10'b0000000_111: return 32;
                default: return -1;
            endcase
            7'b0001111: return (f3 <= 3'd2) ? 33 + int'(f3) : -1;
            7'b1101111: return 36;
            7'b1100111: return 37;
            7'b0110111: return 38;
            7'b0010111: return 39;
            7'b1110011: return (f3 >= 3'd5) ? 35 + int'(f3) : -1;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] dec_imm(input logic [31:0] w, input int op);
        logic [31:0] r = '0;
        if (op <= 5) begin
            r[23:18] = w[31:26]; r[7] = w[25]; r[6:2] = w[11:7];
        end else if (op >= 14 && op <= 19) r[11:0] = w[31:20];
        else if (op >= 20 && op <= 22) r[4:0] = w[24:20];
        else if (op == 36) r[21:2] = w[31:12];
        else if (op == 37) r[13:2] = w[31:20];
        else if (op == 38 || op == 39) r[31:12] = w[31:12];
        else if (op == 40) begin
            r[28:18] = w[31:21]; r[12:7] = w[20:15]; r[6:2] = w[11:7];
        end
        return r;
    endfunction

    function automatic logic [31:0] imm_mask(input int op);
        if (op <= 5) return 32'h00FC_00FC;
        if (op >= 14 && op <= 19) return 32'h0000_0FFF;
        if (op >= 20 && op <= 22) return 32'h0000_001F;
        if (op == 36) return 32'h003F_FFFC;
        if (op == 37) return 32'h0000_3FFC;
        if (op == 38 || op == 39) return 32'hFFFF_F000;
        if (op == 40) return 32'h1FFC_1FFC;
        return 32'h0;
    endfunction

    function automatic bit uses_rd(input int op);
        return (op >= 6 && op <= 10) || (op >= 14 && op <= 32) || (op >= 36 && op <= 39);
    endfunction
    function automatic bit uses_rs1(input int op);
        return (op <= 32 && op != 33) || op == 37;
    endfunction
    function automatic bit uses_rs2(input int op);
        return op <= 5 || (op >= 11 && op <= 13) || (op >= 23 && op <= 32);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", m_tvalid, 1'b0);
            end else begin
                exp_t e;
                int   op;
                e = sb.pop_front();
                if (e.has_word) check("word", instruction, e.word);
                check("warp_out", warp_id_out, e.warp);
                check("tlast_out", m_tlast, e.last);
                if (e.op <= 8'd42) begin
                    op = dec_op(instruction);
                    check("dec_op", op, e.op);
                    if (uses_rd(op))  check("dec_rd", instruction[11:7], e.rd);
                    if (uses_rs1(op)) check("dec_rs1", instruction[19:15], e.rs1);
                    if (uses_rs2(op)) check("dec_rs2", instruction[24:20], e.rs2);
                    check("dec_imm", dec_imm(instruction, op) & imm_mask(op), e.imm & imm_mask(op));
                end
            end
        end
    end

    // Drives one beat from posedge+1, waits for acceptance, returns at
    // posedge+1 just after the accepting edge with s_tvalid still high.
    task automatic send(input logic [7:0] a_op, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                        input logic [4:0] a_rs2, input logic [31:0] a_imm, input logic [4:0] a_warp,
                        input logic a_last, input logic a_has, input logic [31:0] a_word);
        int   n = 0;
        bit   ok = 0;
        exp_t e;
        opcode = a_op; rd = a_rd; rs1 = a_rs1; rs2 = a_rs2; imm = a_imm;
        warp_id_in = a_warp; s_tlast = a_last; s_tvalid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (s_tready) ok = 1; else n++;
        end
        if (!ok) check("accept_timeout", s_tready, 1'b1);
        else if (a_op <= 8'd42 || a_last) begin
            e = '{a_op, a_rd, a_rs1, a_rs2, a_imm, a_warp, a_last, a_has, a_word};
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk); n++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; opcode = '0; rd = '0; rs1 = '0;
        rs2 = '0; imm = '0; warp_id_in = '0; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_warp", warp_id_out, 5'd0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_err", err, 32'h0);
        check("rst_drop", drop_count, 16'd0);
        check("rst_s_tready", s_tready, 1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ADD, latency one edge.
        m_tready = 1'b1;
        send(8'd23, 5'd3, 5'd1, 5'd2, 32'h0, 5'd7, 1'b0, 1'b1, 32'h002081B3);
        s_tvalid = 1'b0;
        check("add_latency_valid", m_tvalid, 1'b1);
        check("add_latency_word", instruction, 32'h002081B3);
        wait_drain();

        // Directed encodings, back to back.
        send(8'd38, 5'd5, 5'd0, 5'd0, 32'h12345000, 5'd1, 1'b0, 1'b1, 32'h123452B7);
        send(8'd0,  5'd0, 5'd1, 5'd2, 32'h0004008C, 5'd2, 1'b0, 1'b1, 32'h062081E3);
        send(8'd22, 5'd4, 5'd4, 5'd0, 32'h7,        5'd3, 1'b1, 1'b1, 32'h40725213);
        s_tvalid = 1'b0;
        wait_drain();

        // Backpressure: two beats fill the FIFO, the third must wait.
        m_tready = 1'b0;
        send(8'd23, 5'd10, 5'd11, 5'd12, 32'h0, 5'd10, 1'b0, 1'b1, 32'h00C58533);
        send(8'd24, 5'd13, 5'd14, 5'd15, 32'h0, 5'd11, 1'b0, 1'b1, 32'h40F706B3);
        opcode = 8'd14; rd = 5'd1; rs1 = 5'd2; imm = 32'h0000_0ABC; warp_id_in = 5'd12;
        s_tlast = 1'b1; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_tready", s_tready, 1'b0);
            check("hold_valid", m_tvalid, 1'b1);
            check("hold_word", instruction, 32'h00C58533);
            check("hold_warp", warp_id_out, 5'd10);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        @(negedge clk);
        check("full_pop_tready", s_tready, 1'b0);
        @(posedge clk); #1;
        send(8'd14, 5'd1, 5'd2, 5'd0, 32'h0000_0ABC, 5'd12, 1'b1, 1'b1, 32'hABC10093);
        s_tvalid = 1'b0;
        wait_drain();

        // Invalid opcode without tlast: dropped, err pulses once.
        send(8'd50, 5'd1, 5'd1, 5'd1, 32'hFFFF_FFFF, 5'd4, 1'b0, 1'b0, 32'h0);
        s_tvalid = 1'b0;
        check("inv_err_set", err != 32'h0, 1'b1);
        check("inv_drop1", drop_count, 16'd1);
        @(negedge clk);
        check("inv_no_beat", m_tvalid, 1'b0);
        @(posedge clk); #1;
        check("inv_err_clear", err, 32'h0);
        check("inv_still_empty", m_tvalid, 1'b0);

        // Invalid opcode closing a packet: NOP with tlast.
        send(8'd50, 5'd1, 5'd1, 5'd1, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b1, 32'h0000_0013);
        s_tvalid = 1'b0;
        check("inv_last_err", err != 32'h0, 1'b1);
        check("inv_drop2", drop_count, 16'd2);
        @(posedge clk); #1;
        check("inv_last_err_clear", err, 32'h0);
        wait_drain();

        // Round trip, streaming with m_tready high: occupancy stays at 1.
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom_range(0, 42)), 5'($urandom), 5'($urandom), 5'($urandom),
                 $urandom, 5'($urandom), 1'($urandom), 1'b0, 32'h0);
            check("stream_tready", s_tready, 1'b1);
        end
        s_tvalid = 1'b0;
        wait_drain();

        // Round trip with random output backpressure.
        rand_run = 1;
        fork
            begin
                while (rand_run) begin
                    @(posedge clk); #1;
                    m_tready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 60; i++) begin
            send(8'($urandom_range(0, 42)), 5'($urandom), 5'($urandom), 5'($urandom),
                 $urandom, 5'($urandom), 1'($urandom), 1'b0, 32'h0);
            if ($urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_tvalid = 1'b0;
        rand_run = 0;
        repeat (2) @(posedge clk);
        #2 m_tready = 1'b1;
        wait_drain();

        // Reset while full flushes everything immediately.
        m_tready = 1'b0;
        send(8'd23, 5'd1, 5'd1, 5'd1, 32'h0, 5'd1, 1'b0, 1'b1, 32'h001080B3);
        send(8'd23, 5'd2, 5'd2, 5'd2, 32'h0, 5'd2, 1'b0, 1'b1, 32'h00210133);
        s_tvalid = 1'b0;
        check("pre_rst_full", s_tready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_tvalid", m_tvalid, 1'b0);
        check("mid_rst_s_tready", s_tready, 1'b1);
        check("mid_rst_drop", drop_count, 16'd0);
        check("mid_rst_instruction", instruction, 32'h0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", m_tvalid, 1'b0);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder for the Kiana SIMT core. It takes decoded micro-op fields (internal opcode number 0–42, rd/rs1/rs2, imm, warp id) and rebuilds the 32-bit Kiana instruction word that the front-end decoder accepts. It is the inverse of that decoder, and the decoder must reproduce the original fields from its output. It sits between the kernel-loader/trace-replay path and instruction memory. It has an AXI-Stream-style handshake on both sides and a 2-entry output FIFO.

## Interface
- No parameters. Widths are fixed by the ISA.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input accept; equals FIFO count != 2.
- s_tlast  in  1  last beat of a kernel packet.
- opcode  in  8  internal opcode number.
- rd, rs1, rs2  in  5 each  register fields.
- imm  in  32  packed immediate, in the decoder's layout.
- warp_id_in  in  5  warp id, passed through.
- m_tvalid  out  1  output beat valid (FIFO non-empty).
- m_tready  in  1  output accept.
- instruction  out  32  encoded word at the FIFO head.
- warp_id_out  out  5  warp id at the FIFO head.
- m_tlast  out  1  tlast at the FIFO head.
- err  out  32  one-cycle error code; 0 when there is no error.
- drop_count  out  16  count of dropped invalid beats; saturates at 16'hFFFF.

## Operation
- A beat is accepted on a clk edge where s_tvalid && s_tready.
- Encoding is combinational on the accepted beat. The result is written into the FIFO at that edge.
- Every field not listed below is encoded as 0. Register inputs are ignored for formats that do not use them.

Encoding by opcode group (op = internal opcode, f3 = funct3, f7 = bits [31:25]):
- B, op 0–5, base 1100011: f3 = 000, 001, 100, 101, 110, 111; rs1, rs2 encoded.
  - [31:26] = imm[23:18]; [25] = imm[7]; [11:7] = imm[6:2].
- Loads, op 6–10, base 0000011: f3 = 000, 001, 010, 100, 101; rd, rs1 encoded.
- Stores, op 11–13, base 0100011: f3 = 000, 001, 010; rs1, rs2 encoded.
- I-type ALU, op 14–22, base 0010011; rd, rs1 encoded.
  - op 14–19: f3 = 000, 010, 011, 100, 110, 111; [31:20] = imm[11:0].
  - op 20, 21 (shifts): f3 = 001, 101; f7 = 0; [24:20] = imm[4:0].
  - op 22: f3 = 101; f7 = 0100000; [24:20] = imm[4:0].
- R-type, op 23–32, base 0110011; rd, rs1, rs2 encoded. {f7, f3} in order:
  - 0000000_000, 0100000_000, 0000000_001, 0000000_010, 0000000_011,
  - 0000000_100, 0000000_101, 0100000_101, 0000000_110, 0000000_111.
- Sync, op 33–35, base 0001111: f3 = 000, 001, 010.
- JAL, op 36, base 1101111: rd encoded; [31:12] = imm[21:2].
- JALR, op 37, base 1100111: rd, rs1 encoded; [31:20] = imm[13:2].
- LUI, op 38, base 0110111, and AUIPC, op 39, base 0010111: rd encoded; [31:12] = imm[31:12].
- P-type, op 40–42, base 1110011: f3 = 101, 110, 111.
  - op 40 only: [31:21] = imm[28:18]; [20:15] = imm[12:7]; [11:7] = imm[6:2].
- Unused imm bits are ignored.

Invalid opcode (> 42) handling:
- The beat is accepted.
- err = `KIANA_SP_ERR_ENCODER_UNKNOWN_OPCODE (from common.svh) for the next cycle.
- drop_count increments.
- If s_tlast = 0, nothing is written to the FIFO.
- If s_tlast = 1, 32'h0000_0013 is written with m_tlast = 1 and the input warp id, so packet framing is preserved.

## Timing
- Reset values: m_tvalid 0, instruction 0, warp_id_out 0, m_tlast 0, err 0, drop_count 0, FIFO count 0, so s_tready = 1.
- Latency: a beat accepted at edge N is presented at the output (if the FIFO was empty) right after edge N, with m_tvalid = 1.
- The output is held stable while m_tvalid && !m_tready.
- Beats leave in order, one per edge where m_tvalid && m_tready.
- s_tready depends only on the FIFO count, never combinationally on m_tready.
  - Full (count 2): s_tready = 0 even if m_tready = 1 in the same cycle.
  - Count 1 with push and pop on the same edge: the count stays 1.
- err is registered: it is nonzero for exactly one cycle per invalid beat, and 0 otherwise.
- rst_n assertion mid-stream immediately flushes the FIFO and returns all outputs to their reset values. Beats in flight are lost.

## Test plan
- ADD (op 23, rd 3, rs1 1, rs2 2, m_tready = 1) -> instruction 32'h002081B3, m_tvalid = 1 one cycle after acceptance.
- LUI (op 38, rd 5, imm 32'h12345000); BEQ (op 0, rs1 1, rs2 2, imm 32'h0004008C); SRAI (op 22, rd 4, rs1 4, imm 7) -> 32'h123452B7, 32'h062081E3, 32'h40725213, in order.
- Hold m_tready = 0 and present 3 beats -> s_tready drops after 2 are accepted and the head stays stable. Release m_tready -> all 3 emerge in order with no loss or duplication.
- op 50 with s_tlast = 0 -> no output beat, err nonzero for 1 cycle, drop_count = 1. op 50 with s_tlast = 1 -> 32'h00000013 with m_tlast = 1, drop_count = 2.
- Round trip: random valid fields through the encoder, then the decoder -> decoder opcode, rd, rs1, rs2 and imm match the originals, compared on the fields each format uses.
- Assert rst_n while the FIFO is full -> m_tvalid = 0 and s_tready = 1 immediately, drop_count = 0.
